// File: rtl/braille_spi_host.sv
// SPI mode-0 host for a braille cell driver: shifts a 32-bit register frame, then pulses the latch strobe.
// Optional trigger command is compiled in with BRAILLE_SPI_HOST_TRIGGER_EN.
module braille_spi_host #(
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 100,
    parameter int GAP_CYCLES   = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        ss_n,
    output logic        latch_data_n,
    input  logic        trigger_req,
    output logic        trigger_in_n
);

    localparam int MAX_AB  = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
    localparam int MAX_CNT = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);

    localparam logic [1:0] KIND_WRITE = 2'd0;
    localparam logic [1:0] KIND_READ  = 2'd1;
    localparam logic [1:0] KIND_TRIG  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SHIFT, S_POSTF, S_LATCH, S_POSTL, S_READ, S_TRIG_LO, S_TRIG_HI
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic          phase_reg;
    logic [4:0]    bit_reg;
    logic [31:0]   tx_reg;
    logic [15:0]   rx_reg;
    logic [15:0]   rdata_reg;
    logic [1:0]    kind_reg;
    logic          rsp_valid_reg;

    logic        in_shift, div_tick, rise_tick, fall_tick, frame_done;
    logic        gap_done, latch_done, ready;
    logic        accept_cmd, accept_trig;
    logic [31:0] frame_next;

    assign in_shift   = (state_reg == S_SHIFT) || (state_reg == S_READ);
    assign div_tick   = in_shift && (cnt_reg == DIV_LAST);
    assign rise_tick  = div_tick && !phase_reg;
    assign fall_tick  = div_tick && phase_reg;
    assign frame_done = fall_tick && (bit_reg == 5'd31);
    assign gap_done   = (cnt_reg == GAP_LAST);
    assign latch_done = (cnt_reg == LATCH_LAST);
    // Ready is withheld during the rsp_valid cycle so a held cmd_valid waits one more clock.
    assign ready      = (state_reg == S_IDLE) && !rsp_valid_reg && !reset;

`ifdef BRAILLE_SPI_HOST_TRIGGER_EN
    assign accept_trig = ready && trigger_req;
    assign accept_cmd  = ready && cmd_valid && !trigger_req;
`else
    logic unused_trigger;
    assign unused_trigger = trigger_req;
    assign accept_trig    = 1'b0;
    assign accept_cmd     = ready && cmd_valid;
`endif

    always_comb begin
        frame_next = {8'h01, cmd_addr, 16'h0000};
        if (accept_trig) begin
            frame_next = 32'h0800_0000;
        end else if (cmd_write) begin
            frame_next = {8'h02, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (accept_cmd || accept_trig) state_next = S_PRE;
            S_PRE:     if (gap_done) state_next = S_SHIFT;
            S_SHIFT:   if (frame_done) state_next = S_POSTF;
            S_POSTF:   if (gap_done) state_next = S_LATCH;
            S_LATCH:   if (latch_done) state_next = S_POSTL;
            S_POSTL: begin
                if (gap_done) begin
                    if (kind_reg == KIND_READ) begin
                        state_next = S_READ;
                    end else if (kind_reg == KIND_TRIG) begin
                        state_next = S_TRIG_LO;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_READ:    if (frame_done) state_next = S_IDLE;
            S_TRIG_LO: if (gap_done) state_next = S_TRIG_HI;
            S_TRIG_HI: if (gap_done) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg       <= '0;
            phase_reg     <= 1'b0;
            bit_reg       <= 5'd0;
            tx_reg        <= 32'h0;
            rx_reg        <= 16'h0;
            rdata_reg     <= 16'h0;
            kind_reg      <= KIND_WRITE;
            rsp_valid_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= (state_reg != S_IDLE) && (state_next == S_IDLE);

            // One counter serves every wait state and the sclk half-period divider.
            if ((state_next != state_reg) || (state_reg == S_IDLE) || div_tick) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end

            if (!in_shift) begin
                phase_reg <= 1'b0;
            end else if (div_tick) begin
                phase_reg <= !phase_reg;
            end

            if (!in_shift) begin
                bit_reg <= 5'd0;
            end else if (fall_tick) begin
                bit_reg <= bit_reg + 5'd1;
            end

            if (accept_cmd || accept_trig) begin
                tx_reg   <= frame_next;
                kind_reg <= accept_trig ? KIND_TRIG : (cmd_write ? KIND_WRITE : KIND_READ);
            end else if ((state_reg == S_POSTL) && (state_next == S_READ)) begin
                tx_reg <= 32'h0;
            end else if (fall_tick) begin
                tx_reg <= {tx_reg[30:0], 1'b0};
            end

            if (rise_tick) begin
                rx_reg <= {rx_reg[14:0], miso};
            end

            if ((state_reg == S_READ) && frame_done) begin
                rdata_reg <= rx_reg;
            end
        end
    end

    always_comb begin
        ss_n         = !in_shift;
        sclk         = in_shift && phase_reg;
        mosi         = in_shift && tx_reg[31];
        latch_data_n = (state_reg != S_LATCH);
`ifdef BRAILLE_SPI_HOST_TRIGGER_EN
        trigger_in_n = (state_reg != S_TRIG_LO);
`else
        trigger_in_n = 1'b1;
`endif
        cmd_ready    = ready;
        rsp_valid    = rsp_valid_reg;
        rsp_rdata    = rdata_reg;
    end

endmodule

// File: tb/tb_braille_spi_host.sv
// Directed bench for braille_spi_host: write, read, timing, back-to-back, mid-frame reset and trigger.
module tb_braille_spi_host;

    localparam int CLK_DIV = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = 8'h00;
    logic [15:0] cmd_wdata = 16'h0000;
    logic        trigger_req = 1'b0;
    logic        miso;
    logic        cmd_ready, rsp_valid, sclk, mosi, ss_n, latch_data_n, trigger_in_n;
    logic [15:0] rsp_rdata;

    braille_spi_host #(.CLK_DIV(CLK_DIV), .LATCH_CYCLES(100), .GAP_CYCLES(20)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n),
        .latch_data_n(latch_data_n), .trigger_req(trigger_req), .trigger_in_n(trigger_in_n)
    );

    always #5 clock = ~clock;

    int pass_cnt = 0;
    int total = 0;

    // Bus monitor, sampled on the falling clock edge.
    int          cyc = 0, frame_cnt = 0, cur_rises = 0, ss_low = 0;
    int          last_rises = 0, last_ss_len = 0;
    int          latch_run = 0, last_latch_len = 0;
    int          trig_run = 0, last_trig_len = 0, trig_low_total = 0;
    int          rsp_cnt = 0, last_rsp_cyc = 0, acc_cnt = 0, last_acc_cyc = 0, stab_err = 0;
    logic [31:0] cap = 32'h0, last_frame = 32'h0;
    logic [31:0] frame_log [0:63];
    logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev2_mosi = 1'b0, mosi_at_rise = 1'b0;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (prev_ss && !ss_n) begin
            ss_low    <= 1;
            cap       <= 32'h0;
            cur_rises <= 0;
        end else begin
            if (!ss_n) ss_low <= ss_low + 1;
            if (!prev_sclk && sclk) begin
                cap          <= {cap[30:0], mosi};
                cur_rises    <= cur_rises + 1;
                mosi_at_rise <= mosi;
                if (!(mosi == prev_mosi && prev_mosi == prev2_mosi)) stab_err <= stab_err + 1;
            end
        end
        if (prev_sclk && !sclk && (prev_mosi != mosi_at_rise)) stab_err <= stab_err + 1;
        if (!prev_ss && ss_n) begin
            frame_log[frame_cnt] <= cap;
            last_frame  <= cap;
            last_rises  <= cur_rises;
            last_ss_len <= ss_low;
            frame_cnt   <= frame_cnt + 1;
        end
        if (!latch_data_n) latch_run <= latch_run + 1;
        else if (latch_run != 0) begin
            last_latch_len <= latch_run;
            latch_run      <= 0;
        end
        if (!trigger_in_n) begin
            trig_run       <= trig_run + 1;
            trig_low_total <= trig_low_total + 1;
        end else if (trig_run != 0) begin
            last_trig_len <= trig_run;
            trig_run      <= 0;
        end
        if (rsp_valid) begin
            rsp_cnt      <= rsp_cnt + 1;
            last_rsp_cyc <= cyc;
        end
        if ((cmd_valid || trigger_req) && cmd_ready) begin
            acc_cnt      <= acc_cnt + 1;
            last_acc_cyc <= cyc;
        end
        prev_ss    <= ss_n;
        prev_sclk  <= sclk;
        prev2_mosi <= prev_mosi;
        prev_mosi  <= mosi;
    end

    // Slave model: first frame of a read returns DEADBEEF, second returns 0000000F.
    int          slave_base = 0;
    logic [31:0] slave_word;
    logic [4:0]  rise_idx;
    assign slave_word = ((frame_cnt - slave_base) == 1) ? 32'h0000_000F : 32'hDEAD_BEEF;
    assign rise_idx   = 5'd31 - cur_rises[4:0];
    assign miso       = ss_n ? 1'b0 : slave_word[rise_idx];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge clock);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 2000) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        check("accept_timeout", {31'h0, n < 2000}, 32'h1);
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_cnt < target && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("rsp_timeout", {31'h0, rsp_cnt >= target}, 32'h1);
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("acc_timeout", {31'h0, acc_cnt >= target}, 32'h1);
    endtask

    int rb, fb, ab, rsp_cyc_first;

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ss_n", {31'h0, ss_n}, 32'h1);
        check("rst_sclk", {31'h0, sclk}, 32'h0);
        check("rst_mosi", {31'h0, mosi}, 32'h0);
        check("rst_latch_n", {31'h0, latch_data_n}, 32'h1);
        check("rst_trigger_in_n", {31'h0, trigger_in_n}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", {16'h0, rsp_rdata}, 32'h0);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", {31'h0, cmd_ready}, 32'h1);

        // Write 02 <- 0004
        rb = rsp_cnt;
        issue(1'b1, 8'h02, 16'h0004);
        wait_rsp(rb + 1);
        repeat (5) @(negedge clock);
        check("wr_frame", last_frame, 32'h0202_0004);
        check("wr_rises", last_rises, 32);
        check("wr_ss_len", last_ss_len, 128);
        check("wr_latch_len", last_latch_len, 100);
        check("wr_rsp_count", rsp_cnt - rb, 1);

        // Read 04
        slave_base = frame_cnt;
        rb = rsp_cnt;
        issue(1'b0, 8'h04, 16'hFFFF);
        wait_rsp(rb + 1);
        repeat (3) @(negedge clock);
        check("rd_frame1", frame_log[slave_base], 32'h0104_0000);
        check("rd_frame2", frame_log[slave_base + 1], 32'h0000_0000);
        check("rd_frames", frame_cnt - slave_base, 2);
        check("rd_rdata", {16'h0, rsp_rdata}, 32'h0000_000F);
        check("rd_ss_len", last_ss_len, 128);

        // Back-to-back writes with cmd_valid held high
        fb = frame_cnt;
        rb = rsp_cnt;
        ab = acc_cnt;
        @(negedge clock);
        cmd_write = 1'b1;
        cmd_addr  = 8'h10;
        cmd_wdata = 16'h1111;
        cmd_valid = 1'b1;
        wait_acc(ab + 1);
        cmd_addr  = 8'h11;
        cmd_wdata = 16'h2222;
        wait_acc(ab + 2);
        cmd_valid = 1'b0;
        check("b2b_rsp_before_2nd", rsp_cnt - rb, 1);
        rsp_cyc_first = last_rsp_cyc;
        check("b2b_accept_after_rsp", {31'h0, last_acc_cyc > rsp_cyc_first}, 32'h1);
        wait_rsp(rb + 2);
        repeat (3) @(negedge clock);
        check("b2b_frame1", frame_log[fb], 32'h0210_1111);
        check("b2b_frame2", frame_log[fb + 1], 32'h0211_2222);
        check("rdata_held_after_wr", {16'h0, rsp_rdata}, 32'h0000_000F);

        // Reset during bit 10 of a frame
        rb = rsp_cnt;
        @(negedge clock);
        cmd_write = 1'b1;
        cmd_addr  = 8'h20;
        cmd_wdata = 16'hABCD;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        begin
            int n = 0;
            while (cur_rises < 10 && n < 2000) begin
                @(negedge clock);
                n++;
            end
            check("mid_frame_reached", {31'h0, n < 2000}, 32'h1);
        end
        #2 reset = 1'b1;
        #1;
        check("midrst_ss_n", {31'h0, ss_n}, 32'h1);
        check("midrst_latch_n", {31'h0, latch_data_n}, 32'h1);
        check("midrst_sclk", {31'h0, sclk}, 32'h0);
        repeat (3) @(negedge clock);
        check("midrst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("midrst_rdata_clr", {16'h0, rsp_rdata}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_ready_after", {31'h0, cmd_ready}, 32'h1);
        repeat (300) @(negedge clock);
        check("midrst_no_rsp", rsp_cnt - rb, 0);

        issue(1'b1, 8'h03, 16'h5A5A);
        wait_rsp(rb + 1);
        repeat (3) @(negedge clock);
        check("post_rst_frame", last_frame, 32'h0203_5A5A);
        check("post_rst_rises", last_rises, 32);
        check("post_rst_ss_len", last_ss_len, 128);

        // Trigger and write requested together
        fb = frame_cnt;
        rb = rsp_cnt;
        ab = acc_cnt;
        @(negedge clock);
        cmd_write   = 1'b1;
        cmd_addr    = 8'h05;
        cmd_wdata   = 16'h0102;
        cmd_valid   = 1'b1;
        trigger_req = 1'b1;
        wait_acc(ab + 1);
        trigger_req = 1'b0;
`ifdef BRAILLE_SPI_HOST_TRIGGER_EN
        wait_acc(ab + 2);
        cmd_valid = 1'b0;
        wait_rsp(rb + 2);
        repeat (3) @(negedge clock);
        check("trg_frame", frame_log[fb], 32'h0800_0000);
        check("trg_low_len", last_trig_len, 20);
        check("trg_low_total", trig_low_total, 20);
        check("trg_then_write", frame_log[fb + 1], 32'h0205_0102);
        check("trg_frames", frame_cnt - fb, 2);
`else
        cmd_valid = 1'b0;
        wait_rsp(rb + 1);
        repeat (5) @(negedge clock);
        check("notrg_frame", frame_log[fb], 32'h0205_0102);
        check("notrg_frames", frame_cnt - fb, 1);
        check("notrg_low_total", trig_low_total, 0);
        check("notrg_trigger_in_n", {31'h0, trigger_in_n}, 32'h1);
`endif

        check("mosi_stable", stab_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
